alu_issue_stage: RTL and testbench

ID/EX issue stage that sits directly upstream of the ALU. It accepts a decoded instruction over a valid/ready handshake, selects and forwards the operands, and presents a registered `alu_in_t` (a, b, op) plus destination tag to the ALU. A two-entry skid buffer fully decouples upstream ready from downstream ready, with no combinational path between them. A flush input discards in-flight work on branch or trap redirect.

---
 rtl/alu_issue_stage.sv | 129 ++++++++++++
 tb/tb_alu_issue_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: resolves and forwards operands at capture, then presents a
// registered ALU request through a two-entry skid buffer (main M, skid S).
package alu_issue_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        alu_op_e     op;
    } alu_in_t;
endpackage

module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  alu_op_e     op_i,
    input  logic [1:0]  a_sel_i,
    input  logic [1:0]  b_sel_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  rd_i,
    input  logic        we_i,
    input  logic        fwd_we_i,
    input  logic [4:0]  fwd_rd_i,
    input  logic [31:0] fwd_data_i,
    output alu_in_t     alu_in_o,
    output logic [4:0]  rd_o,
    output logic        we_o,
    output logic        valid_o,
    input  logic        ready_i
);
    typedef struct packed {
        alu_in_t    alu;
        logic [4:0] rd;
        logic       we;
    } entry_t;

    logic        m_v, s_v;
    entry_t      m_q, s_q, cap;
    logic [31:0] rs1_val, rs2_val;
    logic        accept, drain, load_m, load_s;

    assign ready_o = !s_v;
    assign valid_o = m_v;
    assign accept  = valid_i && ready_o;
    assign drain   = m_v && ready_i;

    // Skid entry always refills M first so order is preserved.
    assign load_m = s_v ? drain : (accept && (!m_v || drain));
    assign load_s = m_v && !s_v && accept && !drain;

    always_comb begin
        rs1_val = rs1_data_i;
        rs2_val = rs2_data_i;
        if (FWD_EN && fwd_we_i && fwd_rd_i != 5'd0 && fwd_rd_i == rs1_addr_i)
            rs1_val = fwd_data_i;
        if (FWD_EN && fwd_we_i && fwd_rd_i != 5'd0 && fwd_rd_i == rs2_addr_i)
            rs2_val = fwd_data_i;

        cap        = '0;
        cap.alu.op = op_i;
        cap.rd     = rd_i;
        cap.we     = we_i;
        case (a_sel_i)
            2'b00:   cap.alu.a = rs1_val;
            2'b01:   cap.alu.a = pc_i;
            default: cap.alu.a = 32'd0;
        endcase
        case (b_sel_i)
            2'b00:   cap.alu.b = rs2_val;
            2'b01:   cap.alu.b = imm_i;
            2'b10:   cap.alu.b = 32'd4;
            default: cap.alu.b = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
        end else if (flush_i) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
        end else if (!m_v) begin
            m_v <= accept;
        end else if (!s_v) begin
            if (accept && !drain)
                s_v <= 1'b1;
            else if (!accept && drain)
                m_v <= 1'b0;
        end else if (drain) begin
            s_v <= 1'b0;
        end
    end

    // Payload carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (load_m)
            m_q <= s_v ? s_q : cap;
        if (load_s)
            s_q <= cap;
    end

    assign alu_in_o = m_q.alu;
    assign rd_o     = m_q.rd;
    assign we_o     = m_q.we & m_v;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and randomized checks of alu_issue_stage against a queue-based model.
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush_i, valid_i, ready_i;
    alu_op_e     op_i;
    logic [1:0]  a_sel_i, b_sel_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_i, fwd_rd_i;
    logic [31:0] rs1_data_i, rs2_data_i, pc_i, imm_i, fwd_data_i;
    logic        we_i, fwd_we_i;

    alu_in_t     alu_in, alu_in0;
    logic [4:0]  rd_o, rd0;
    logic        we_o, valid_o, ready_o, we0, valid0, ready0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t q[$];
    exp_t e;
    bit   acc, drn;
    int   n_pass = 0, n_fail = 0, n_total = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .a_sel_i(a_sel_i), .b_sel_i(b_sel_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .pc_i(pc_i), .imm_i(imm_i), .rd_i(rd_i), .we_i(we_i),
        .fwd_we_i(fwd_we_i), .fwd_rd_i(fwd_rd_i), .fwd_data_i(fwd_data_i),
        .alu_in_o(alu_in), .rd_o(rd_o), .we_o(we_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    alu_issue_stage #(.FWD_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready0),
        .op_i(op_i), .a_sel_i(a_sel_i), .b_sel_i(b_sel_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .pc_i(pc_i), .imm_i(imm_i), .rd_i(rd_i), .we_i(we_i),
        .fwd_we_i(fwd_we_i), .fwd_rd_i(fwd_rd_i), .fwd_data_i(fwd_data_i),
        .alu_in_o(alu_in0), .rd_o(rd0), .we_o(we0), .valid_o(valid0), .ready_i(ready_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected captured entry from the current input values.
    function automatic exp_t model_entry();
        exp_t r;
        logic [31:0] s1, s2;
        s1 = (fwd_we_i && fwd_rd_i != 0 && fwd_rd_i == rs1_addr_i) ? fwd_data_i : rs1_data_i;
        s2 = (fwd_we_i && fwd_rd_i != 0 && fwd_rd_i == rs2_addr_i) ? fwd_data_i : rs2_data_i;
        r.a  = (a_sel_i == 0) ? s1 : (a_sel_i == 1) ? pc_i : 32'd0;
        r.b  = (b_sel_i == 0) ? s2 : (b_sel_i == 1) ? imm_i : (b_sel_i == 2) ? 32'd4 : 32'd0;
        r.op = op_i;
        r.rd = rd_i;
        r.we = we_i;
        return r;
    endfunction

    initial begin
        rst = 1'b1; flush_i = 0; valid_i = 0; ready_i = 0; op_i = ALU_ADD;
        a_sel_i = 0; b_sel_i = 0; rs1_addr_i = 0; rs2_addr_i = 0; rd_i = 0;
        fwd_rd_i = 0; rs1_data_i = 0; rs2_data_i = 0; pc_i = 0; imm_i = 0;
        fwd_data_i = 0; we_i = 0; fwd_we_i = 0;
        tick(); tick();
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_we", we_o, 0);
        check("rst_valid_nofwd", valid0, 0);

        // single entry
        rst = 0; valid_i = 1; op_i = ALU_ADD; a_sel_i = 2'b00; b_sel_i = 2'b01;
        rs1_data_i = 5; imm_i = 7; rd_i = 3; we_i = 1;
        check("pre_valid", valid_o, 0);
        check("pre_ready", ready_o, 1);
        tick();
        valid_i = 0;
        check("one_valid", valid_o, 1);
        check("one_a", alu_in.a, 5);
        check("one_b", alu_in.b, 7);
        check("one_op", 32'(alu_in.op), 32'(ALU_ADD));
        check("one_rd", rd_o, 3);
        check("one_we", we_o, 1);
        ready_i = 1;
        tick();
        check("one_drained", valid_o, 0);

        // forwarding
        valid_i = 1; a_sel_i = 0; b_sel_i = 0;
        rs1_addr_i = 4; rs1_data_i = 1; rs2_addr_i = 4; rs2_data_i = 2;
        fwd_we_i = 1; fwd_rd_i = 4; fwd_data_i = 32'hDEAD_BEEF;
        tick();
        check("fwd_a", alu_in.a, 32'hDEAD_BEEF);
        check("fwd_b", alu_in.b, 32'hDEAD_BEEF);
        check("nofwd_a", alu_in0.a, 1);
        check("nofwd_b", alu_in0.b, 2);
        check("nofwd_valid", valid0, 1);
        check("nofwd_ready", ready0, 1);
        check("nofwd_rd", rd0, 3);
        check("nofwd_we", we0, 1);
        rs1_addr_i = 0; fwd_rd_i = 0; rs1_data_i = 32'h55; rs2_addr_i = 9;
        tick();
        check("fwd_x0_a", alu_in.a, 32'h55);
        check("fwd_x0_b", alu_in.b, 2);
        rs1_addr_i = 4; fwd_rd_i = 4; fwd_we_i = 0; rs1_data_i = 1;
        tick();
        check("fwd_off_a", alu_in.a, 1);
        valid_i = 0;
        tick();
        check("fwd_drained", valid_o, 0);

        // back-pressure: entries tagged through imm
        a_sel_i = 2'b10; b_sel_i = 2'b01; ready_i = 0; valid_i = 1;
        imm_i = 1; tick();
        check("bp1_b", alu_in.b, 1);
        check("bp1_ready", ready_o, 1);
        imm_i = 2; tick();
        check("bp2_ready", ready_o, 0);
        check("bp2_b", alu_in.b, 1);
        imm_i = 3; tick();
        check("bp3_ready", ready_o, 0);
        check("bp3_hold_b", alu_in.b, 1);
        ready_i = 1; tick();
        check("bp_out2", alu_in.b, 2);
        check("bp_ready_back", ready_o, 1);
        tick();
        check("bp_out3", alu_in.b, 3);
        check("bp_out3_valid", valid_o, 1);
        valid_i = 0; tick();
        check("bp_empty", valid_o, 0);

        // flush while FULL with an accept attempt
        ready_i = 0; valid_i = 1; imm_i = 10; tick();
        imm_i = 11; tick();
        check("fl_full", ready_o, 0);
        flush_i = 1; imm_i = 12; tick();
        flush_i = 0; valid_i = 0;
        check("fl_valid", valid_o, 0);
        check("fl_we", we_o, 0);
        check("fl_ready", ready_o, 1);
        ready_i = 1; tick();
        check("fl_gone", valid_o, 0);
        // flush in ONE drops a same-cycle accept
        ready_i = 0; valid_i = 1; imm_i = 20; tick();
        flush_i = 1; imm_i = 21; tick();
        flush_i = 0; valid_i = 0;
        check("fl1_valid", valid_o, 0);

        // operand selects
        ready_i = 1; valid_i = 1; imm_i = 32'h77; rs2_data_i = 32'h99; rs1_data_i = 32'h33;
        a_sel_i = 2'b01; pc_i = 32'h100; b_sel_i = 2'b10; tick();
        check("sel_pc", alu_in.a, 32'h100);
        check("sel_four", alu_in.b, 4);
        a_sel_i = 2'b10; tick();
        check("sel_zero", alu_in.a, 0);
        a_sel_i = 2'b11; b_sel_i = 2'b11; tick();
        check("sel_a_rsv", alu_in.a, 0);
        check("sel_b_rsv", alu_in.b, 0);

        // reset mid-transfer
        ready_i = 0; b_sel_i = 2'b01; tick(); tick();
        rst = 1; tick();
        rst = 0; valid_i = 0;
        check("rstmid_valid", valid_o, 0);
        check("rstmid_ready", ready_o, 1);
        check("rstmid_we", we_o, 0);

        // randomized against queue model
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            check("rnd_valid", valid_o, 32'(q.size() > 0));
            check("rnd_ready", ready_o, 32'(q.size() < 2));
            if (q.size() > 0) begin
                check("rnd_a", alu_in.a, q[0].a);
                check("rnd_b", alu_in.b, q[0].b);
                check("rnd_op", 32'(alu_in.op), 32'(q[0].op));
                check("rnd_rd", rd_o, 32'(q[0].rd));
                check("rnd_we", we_o, 32'(q[0].we));
            end else begin
                check("rnd_we_idle", we_o, 0);
            end
            rst        = ($urandom_range(0, 499) == 0);
            flush_i    = ($urandom_range(0, 39) == 0);
            valid_i    = ($urandom_range(0, 3) != 0);
            ready_i    = ($urandom_range(0, 2) != 0);
            op_i       = alu_op_e'(4'($urandom_range(0, 9)));
            a_sel_i    = 2'($urandom);
            b_sel_i    = 2'($urandom);
            rs1_addr_i = 5'($urandom_range(0, 7));
            rs2_addr_i = 5'($urandom_range(0, 7));
            fwd_rd_i   = 5'($urandom_range(0, 7));
            fwd_we_i   = 1'($urandom);
            rd_i       = 5'($urandom);
            we_i       = 1'($urandom);
            rs1_data_i = $urandom;
            rs2_data_i = $urandom;
            pc_i       = $urandom;
            imm_i      = $urandom;
            fwd_data_i = $urandom;
            e   = model_entry();
            acc = valid_i && (q.size() < 2);
            drn = (q.size() > 0) && ready_i;
            tick();
            if (rst || flush_i) begin
                q.delete();
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
